// File: rtl/gin_leak_sequencer.sv
// Per-timestep inhibitory-conductance leak sweep: read gin/Taugin, feed the
// leak unit, write the leaked value back. Three cycles per neuron.
`timescale 1ns/1ps
module gin_leak_sequencer #(
  parameter int INTEGER_WIDTH   = 16,
  parameter int DATA_WIDTH_FRAC = 32,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int DELTAT_WIDTH    = 4,
  parameter int NEURON_WIDTH    = 11
) (
  input  logic                     Clock_i,
  input  logic                     Reset_i,
  input  logic                     Start_i,
  input  logic [NEURON_WIDTH-1:0]  NeuronStart_i,
  input  logic [NEURON_WIDTH-1:0]  NeuronEnd_i,
  input  logic [DELTAT_WIDTH-1:0]  DeltaT_i,
  output logic                     Busy_o,
  output logic                     Done_o,
  output logic                     ErrorTauZero_o,
  output logic                     GinREn_o,
  output logic [NEURON_WIDTH-1:0]  GinRAddr_o,
  input  logic [DATA_WIDTH-1:0]    GinRData_i,
  input  logic [INTEGER_WIDTH-1:0] TauginRData_i,
  output logic [DATA_WIDTH-1:0]    LeakGin_o,
  output logic [DELTAT_WIDTH-1:0]  LeakDeltaT_o,
  output logic [INTEGER_WIDTH-1:0] LeakTaugin_o,
  input  logic [DATA_WIDTH-1:0]    LeakGinOut_i,
  output logic                     GinWEn_o,
  output logic [NEURON_WIDTH-1:0]  GinWAddr_o,
  output logic [DATA_WIDTH-1:0]    GinWData_o
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [NEURON_WIDTH-1:0]  n_q, n_d, end_q, end_d;
  logic [DELTAT_WIDTH-1:0]  dt_q, dt_d;
  logic                     err_q, err_d, skip_q, skip_d;
  logic [DATA_WIDTH-1:0]    lgin_q, lgin_d;
  logic [DELTAT_WIDTH-1:0]  ldt_q, ldt_d;
  logic [INTEGER_WIDTH-1:0] ltau_q, ltau_d;
  logic                     ren_q, ren_d, wen_q, wen_d, done_q, done_d, busy_q, busy_d;
  logic [NEURON_WIDTH-1:0]  raddr_q, raddr_d, waddr_q, waddr_d;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    end_d   = end_q;
    dt_d    = dt_q;
    err_d   = err_q;
    skip_d  = skip_q;
    lgin_d  = lgin_q;
    ldt_d   = ldt_q;
    ltau_d  = ltau_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    case (state_q)
      S_IDLE: if (Start_i) begin
        end_d   = NeuronEnd_i;
        dt_d    = DeltaT_i;
        err_d   = 1'b0;
        n_d     = NeuronStart_i;
        state_d = (NeuronEnd_i < NeuronStart_i) ? S_DONE : S_READ;
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        lgin_d  = GinRData_i;
        ltau_d  = TauginRData_i;
        ldt_d   = dt_q;
        skip_d  = (TauginRData_i == '0);
        if (TauginRData_i == '0) err_d = 1'b1;
        state_d = S_WRITE;
      end
      // Equality stop before increment keeps n from wrapping at the top index.
      S_WRITE: begin
        if (n_q == end_q) state_d = S_DONE;
        else begin
          n_d     = n_q + 1'b1;
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Strobes are registered from the next state so they line up with it.
    ren_d  = (state_d == S_READ);
    wen_d  = (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
    if (ren_d) raddr_d = n_d;
    if (wen_d) waddr_d = n_d;
  end

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      end_q   <= '0;
      dt_q    <= '0;
      err_q   <= 1'b0;
      skip_q  <= 1'b0;
      lgin_q  <= '0;
      ldt_q   <= '0;
      ltau_q  <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      end_q   <= end_d;
      dt_q    <= dt_d;
      err_q   <= err_d;
      skip_q  <= skip_d;
      lgin_q  <= lgin_d;
      ldt_q   <= ldt_d;
      ltau_q  <= ltau_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
    end
  end

  assign Busy_o         = busy_q;
  assign Done_o         = done_q;
  assign ErrorTauZero_o = err_q;
  assign GinREn_o       = ren_q;
  assign GinRAddr_o     = raddr_q;
  assign LeakGin_o      = lgin_q;
  assign LeakDeltaT_o   = ldt_q;
  assign LeakTaugin_o   = ltau_q;
  assign GinWEn_o       = wen_q;
  assign GinWAddr_o     = waddr_q;
  // A zero Taugin would divide by zero in the leak unit; keep gin as read.
  assign GinWData_o     = skip_q ? lgin_q : LeakGinOut_i;

endmodule

// File: doc/gin_leak_sequencer.md
Name: gin_leak_sequencer

Overview:
- Sequential controller that sweeps a contiguous range of neuron indices once per timestep and applies the inhibitory-conductance leak to each one.
- Per neuron it reads gin from the conductance RAM and Taugin from the parameter RAM, then drives the combinational leak unit with them. It writes the leaked value back to the conductance RAM.
- Sits directly upstream of the leak unit (feeds it) and is started by the timestep controller.

Parameters:
INTEGER_WIDTH, 16, integer bits of Q-format conductance
DATA_WIDTH_FRAC, 32, fractional bits of Q-format conductance
DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, full conductance word width
DELTAT_WIDTH, 4, timestep field width (MSB-aligned fraction, value = DeltaT*2^-DELTAT_WIDTH)
NEURON_WIDTH, 11, neuron address width

Ports:
Clock  in  1  single clock, all state on rising edge
Reset  in  1  synchronous, active-high
Start  in  1  one-cycle pulse, begins a sweep (sampled only in IDLE)
NeuronStart  in  NEURON_WIDTH  first neuron index (inclusive), latched at Start
NeuronEnd  in  NEURON_WIDTH  last neuron index (inclusive), latched at Start
DeltaT  in  DELTAT_WIDTH  timestep, latched at Start
Busy  out  1  high from the cycle after Start until Done inclusive
Done  out  1  one-cycle pulse at sweep end
ErrorTauZero  out  1  sticky; set when any Taugin==0 is read; cleared at next accepted Start
GinREn  out  1  conductance/parameter RAM read enable
GinRAddr  out  NEURON_WIDTH  read address (shared by both RAMs)
GinRData  in  DATA_WIDTH  gin read data, valid 1 cycle after GinREn
TauginRData  in  INTEGER_WIDTH  Taugin read data, valid 1 cycle after GinREn
LeakGin  out  DATA_WIDTH  registered gin to leak unit
LeakDeltaT  out  DELTAT_WIDTH  registered DeltaT to leak unit
LeakTaugin  out  INTEGER_WIDTH  registered Taugin to leak unit
LeakGinOut  in  DATA_WIDTH  combinational result from leak unit
GinWEn  out  1  conductance RAM write enable
GinWAddr  out  NEURON_WIDTH  write address
GinWData  out  DATA_WIDTH  write data

Behaviour:
- States: IDLE, READ, CAPTURE, WRITE, DONE.
- Reset (any state, including mid-sweep): go to IDLE. Clear Busy, Done, GinREn, GinWEn, ErrorTauZero, the Leak* registers and the address counter. No write is issued in the reset cycle or the cycle after.
- IDLE:
  - On Start, latch NeuronStart/NeuronEnd/DeltaT, clear ErrorTauZero, and load counter n=NeuronStart.
  - If NeuronEnd<NeuronStart (unsigned compare), go straight to DONE with no RAM accesses; otherwise go to READ.
- READ (1 cycle): GinREn=1, GinRAddr=n. Go to CAPTURE.
- CAPTURE (1 cycle):
  - Register GinRData→LeakGin, TauginRData→LeakTaugin, latched DeltaT→LeakDeltaT. Go to WRITE.
  - If TauginRData==0, set ErrorTauZero and set a local skip flag.
- WRITE (1 cycle):
  - GinWEn=1, GinWAddr=n.
  - GinWData=LeakGinOut, or LeakGin unchanged if the skip flag is set (the divide-by-zero result is never written).
  - If n==NeuronEnd, go to DONE; else n=n+1 and go to READ.
- DONE (1 cycle): Done=1, Busy=1, then go to IDLE.
- Throughput and latency:
  - 3 cycles per neuron.
  - For N=NeuronEnd-NeuronStart+1 neurons, Done asserts 3N+1 cycles after the Start cycle.
- Termination is by equality compare. The counter never wraps: NeuronEnd=2^NEURON_WIDTH-1 terminates correctly without n overflowing into the compare.
- Start while Busy is ignored; latched range and DeltaT do not change.
- GinREn and GinWEn are never high in the same cycle. GinRAddr/GinWAddr hold their last value when the enables are low.
- All outputs other than GinWData are registered. GinWData may be combinational from LeakGinOut.

Test Plan:
- Single neuron: NeuronStart=NeuronEnd=5, gin=0x0001_00000000 (1.0), Taugin=2, DeltaT=4'b1000 (0.5) → one write to addr 5 with data 0x0000_C0000000 (0.75). Done exactly 4 cycles after Start; ErrorTauZero=0.
- Range sweep: NeuronStart=0, NeuronEnd=3, distinct gin values → reads 0,1,2,3 in order, each followed two cycles later by a write to the same address. Done at cycle 13.
- Zero tau: neuron 2 has Taugin=0, gin=0x0002_00000000 → addr 2 rewritten with 0x0002_00000000 and ErrorTauZero=1 after the sweep. A following Start clears it.
- Empty and top-of-range: NeuronEnd<NeuronStart → Done 1 cycle after Start, no GinREn/GinWEn. Start=End=2047 → single access at 2047, clean Done.
- Start while Busy: pulse Start again mid-sweep with a different range → ignored; original range completes unchanged.
- Reset mid-op: assert Reset in the CAPTURE state of neuron 1 of 0..3 → IDLE next cycle, no write to addr 1, Busy=0. A new Start then runs normally.
